digital_tube_driver: RTL

- Memory-mapped display peripheral inside the mips top, downstream of the CPU bridge.
- Holds a 32-bit display word and a control word written by software.
- Time-multiplexes 8 hex digits across two 4-digit 7-segment banks: bank 0 shows bits [15:0], bank 1 shows bits [31:16].
- Produces the board-level digital_tube outputs consumed by the testbench and the pins.

---
 rtl/digital_tube_driver_pkg.sv | 21 ++
 rtl/digital_tube_driver_if.sv | 11 +
 rtl/digital_tube_driver_hex_to_seg7.sv | 17 +
 rtl/digital_tube_driver.sv | 121 ++++++++++++
 4 files changed

// File: rtl/digital_tube_driver_pkg.sv
// Shared constants for the digital tube display peripheral:
// register offsets, blank pattern and the active-low hex segment table.
package digital_tube_driver_pkg;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the code for hex digit n with dp off; index 15 is leftmost.
    localparam logic [15:0][7:0] SEG7 = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef struct packed {
        logic dpmask;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/digital_tube_driver_if.sv
// CPU-bridge register bus of the digital tube peripheral.
interface digital_tube_driver_if;
    logic        we;
    logic        addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, addr, be, wdata, input rdata);
    modport slave  (input we, addr, be, wdata, output rdata);
endinterface

// File: rtl/digital_tube_driver_hex_to_seg7.sv
// Combinational hex nibble to 7-segment (active-low, a..g) decoder.
module digital_tube_driver_hex_to_seg7
    import digital_tube_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    logic [7:0] code_s;

    // Table lookup; dp is handled by the caller.
    always_comb begin
        code_s = SEG7[nibble_i];
        seg_o  = code_s[6:0];
    end

endmodule

// File: rtl/digital_tube_driver.sv
// Memory-mapped 8-digit hex display: DATA/CTRL registers, digit scan
// counter and registered segment/select outputs for two 4-digit banks.
module digital_tube_driver
    import digital_tube_driver_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    digital_tube_driver_if.slave       bus,
    output logic [7:0]                 digital_tube0,
    output logic [3:0]                 digital_tube_sel0,
    output logic [7:0]                 digital_tube1,
    output logic [3:0]                 digital_tube_sel1
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_q, data_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       tube0_q, tube0_d, tube1_q, tube1_d;
    logic [3:0]       sel_q, sel_d;

    logic [15:0]      hi_half_s;
    logic [3:0]       nib0_s, nib1_s;
    logic [6:0]       seg0_s, seg1_s;
    logic             dp_s;

    // Register write decode with per-byte enables.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (bus.we && (bus.addr == ADDR_DATA)) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be[k]) begin
                    data_d[8*k +: 8] = bus.wdata[8*k +: 8];
                end else begin
                    data_d[8*k +: 8] = data_q[8*k +: 8];
                end
            end
        end else if (bus.we && (bus.addr == ADDR_CTRL) && bus.be[0]) begin
            ctrl_d = bus.wdata[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Free-running digit scan, independent of EN.
    always_comb begin
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d      = idx_q;
        end
    end

    assign hi_half_s = data_q[31:16];
    assign nib0_s    = data_q[{idx_q, 2'b00} +: 4];
    assign nib1_s    = hi_half_s[{idx_q, 2'b00} +: 4];
    assign dp_s      = ~(ctrl_q.dpmask & (idx_q == 2'd0));

    digital_tube_driver_hex_to_seg7 u_seg_bank0 (.nibble_i(nib0_s), .seg_o(seg0_s));
    digital_tube_driver_hex_to_seg7 u_seg_bank1 (.nibble_i(nib1_s), .seg_o(seg1_s));

    // Output stage next value from current registers (uniform one-cycle lag).
    always_comb begin
        tube0_d = SEG_BLANK;
        tube1_d = SEG_BLANK;
        sel_d   = 4'h0;
        if (ctrl_q.en) begin
            tube0_d = {dp_s, seg0_s};
            tube1_d = {dp_s, seg1_s};
            sel_d   = 4'b0001 << idx_q;
        end else begin
            tube0_d = SEG_BLANK;
            tube1_d = SEG_BLANK;
            sel_d   = 4'h0;
        end
    end

    // Combinational register readback.
    always_comb begin
        if (bus.addr == ADDR_CTRL) begin
            bus.rdata = {30'b0, ctrl_q};
        end else begin
            bus.rdata = data_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= 32'h0;
            ctrl_q     <= 2'b01;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            tube0_q    <= SEG_BLANK;
            tube1_q    <= SEG_BLANK;
            sel_q      <= 4'h0;
        end else begin
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            tube0_q    <= tube0_d;
            tube1_q    <= tube1_d;
            sel_q      <= sel_d;
        end
    end

    assign digital_tube0     = tube0_q;
    assign digital_tube1     = tube1_q;
    assign digital_tube_sel0 = sel_q;
    assign digital_tube_sel1 = sel_q;

endmodule
